// File: rtl/pri_scan_encoder.sv
// +-----------------------------------------------------------------------------+
// | Module      : pri_scan_encoder                                              |
// | Description : Captures a request vector and emits its set-bit indices one   |
// |               at a time, highest first (lowest first with the macro         |
// |               PRI_SCAN_LSB_FIRST_EN), then pulses done with the count.      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pri_scan_encoder #(
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   output logic             busy,
   output logic [IDX_W-1:0] idx,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic             done,
   output logic             none,
   output logic [IDX_W:0]   cnt
);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_SCAN = 2'd1;
   localparam logic [1:0] c_ST_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [WIDTH-1:0] r_vec;
   logic [IDX_W:0]   r_cnt;
   logic             r_none;
   logic [IDX_W-1:0] w_idx;
   logic [WIDTH-1:0] w_vec_clr;
   logic             w_accept;
   logic             w_load_go;

   // Priority select over the registered vector; the last match in loop order wins.
   always_comb begin
      w_idx = '0;
`ifdef PRI_SCAN_LSB_FIRST_EN
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (r_vec[i]) w_idx = IDX_W'(i);
      end
`else
      for (int i = 0; i < WIDTH; i++) begin
         if (r_vec[i]) w_idx = IDX_W'(i);
      end
`endif
   end

   assign w_vec_clr = r_vec & ~(WIDTH'(1) << w_idx);
   assign w_accept  = (r_state == c_ST_SCAN) && idx_ready;
   assign w_load_go = (r_state == c_ST_IDLE) && load;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (load) begin
               w_next_state = (d == '0) ? c_ST_DONE : c_ST_SCAN;
            end
         end
         c_ST_SCAN: begin
            if (idx_ready && (w_vec_clr == '0)) begin
               w_next_state = c_ST_DONE;
            end
         end
         c_ST_DONE: w_next_state = c_ST_IDLE;
         default:   w_next_state = c_ST_IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec  <= '0;
         r_cnt  <= '0;
         r_none <= 1'b0;
      end else if (w_load_go) begin
         r_vec  <= d;
         r_cnt  <= '0;
         r_none <= (d == '0);
      end else if (w_accept) begin
         r_vec  <= w_vec_clr;
         r_cnt  <= r_cnt + (IDX_W+1)'(1);
      end
   end

   // Output decode, from registered state only
   always_comb begin
      busy      = (r_state != c_ST_IDLE);
      idx_valid = (r_state == c_ST_SCAN);
      done      = (r_state == c_ST_DONE);
      none      = (r_state == c_ST_DONE) && r_none;
      idx       = w_idx;
      cnt       = r_cnt;
   end

endmodule

`default_nettype wire

// File: tb/tb_pri_scan_encoder.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_pri_scan_encoder                                           |
// | Description : Directed scoreboard bench for pri_scan_encoder (WIDTH=8).     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_pri_scan_encoder;

   localparam int WIDTH = 8;
   localparam int IDX_W = 3;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] d;
   logic             load;
   logic             busy;
   logic [IDX_W-1:0] idx;
   logic             idx_valid;
   logic             idx_ready;
   logic             done;
   logic             none;
   logic [IDX_W:0]   cnt;

   typedef struct {
      bit is_done;
      int idx;
      int cnt;
      bit none;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   pri_scan_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .d         (d),
      .load      (load),
      .busy      (busy),
      .idx       (idx),
      .idx_valid (idx_valid),
      .idx_ready (idx_ready),
      .done      (done),
      .none      (none),
      .cnt       (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected event stream for one load of vector v.
   task automatic push_scan(input logic [WIDTH-1:0] v);
      exp_t e;
      int   n = 0;
      if (v == '0) begin
         e = '{is_done: 1'b1, idx: 0, cnt: 0, none: 1'b1};
         sb.push_back(e);
      end else begin
`ifdef PRI_SCAN_LSB_FIRST_EN
         for (int i = 0; i < WIDTH; i++) begin
`else
         for (int i = WIDTH - 1; i >= 0; i--) begin
`endif
            if (v[i]) begin
               e = '{is_done: 1'b0, idx: i, cnt: 0, none: 1'b0};
               sb.push_back(e);
               n++;
            end
         end
         e = '{is_done: 1'b1, idx: 0, cnt: n, none: 1'b0};
         sb.push_back(e);
      end
   endtask

   // Observe the combination the next rising edge will see, then advance one clock.
   task automatic cycle();
      exp_t e;
      if (idx_valid && idx_ready) begin
         if (sb.size() == 0) chk("unexpected_idx", 32'(idx), 32'hFFFF);
         else begin
            e = sb.pop_front();
            chk("kind_at_idx", 32'(e.is_done), 32'd0);
            chk("idx", 32'(idx), 32'(e.idx));
         end
      end
      if (done) begin
         if (sb.size() == 0) chk("unexpected_done", 32'(cnt), 32'hFFFF);
         else begin
            e = sb.pop_front();
            chk("kind_at_done", 32'(e.is_done), 32'd1);
            chk("done_cnt", 32'(cnt), 32'(e.cnt));
            chk("done_none", 32'(none), 32'(e.none));
         end
      end
      chk("valid_done_excl", 32'(idx_valid && done), 32'd0);
      chk("none_without_done", 32'(none && !done), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles, output int used);
      used = 0;
      while (sb.size() != 0 && used < max_cycles) begin
         cycle();
         used++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic do_load(input logic [WIDTH-1:0] v);
      push_scan(v);
      d    = v;
      load = 1'b1;
      cycle();
      load = 1'b0;
      d    = '0;
   endtask

   initial begin
      int used;
      rst_n     = 1'b0;
      d         = '0;
      load      = 1'b0;
      idx_ready = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(idx_valid), 32'd0);
      chk("rst_idx", 32'(idx), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_none", 32'(none), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Two requests, first idx on the clock after load, one per clock after.
      do_load(8'b0010_0010);
      chk("latency_valid", 32'(idx_valid), 32'd1);
      chk("latency_busy", 32'(busy), 32'd1);
      drain(20, used);
      chk("tput_22", 32'(used), 32'd3);
      chk("idle_after_22", 32'(busy), 32'd0);

      // Zero vector goes straight to DONE with none.
      do_load(8'h00);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_none", 32'(none), 32'd1);
      drain(5, used);

      // Full vector with count reaching WIDTH.
      do_load(8'hFF);
      drain(30, used);
      chk("tput_ff", 32'(used), 32'd9);

      // Stall: idx held with idx_valid high while idx_ready is low.
      idx_ready = 1'b0;
      do_load(8'b0000_1001);
      for (int k = 0; k < 3; k++) begin
         chk("stall_valid", 32'(idx_valid), 32'd1);
`ifdef PRI_SCAN_LSB_FIRST_EN
         chk("stall_idx", 32'(idx), 32'd0);
`else
         chk("stall_idx", 32'(idx), 32'd3);
`endif
         chk("stall_cnt", 32'(cnt), 32'd0);
         cycle();
      end
      idx_ready = 1'b1;
      drain(20, used);

      // Asynchronous reset mid-scan aborts without done.
      do_load(8'b0001_1111);
      cycle();
      cycle();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(idx_valid), 32'd0);
      chk("abort_idx", 32'(idx), 32'd0);
      chk("abort_cnt", 32'(cnt), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      chk("abort_done_hold", 32'(done), 32'd0);
      rst_n = 1'b1;
      do_load(8'b0000_0001);
      chk("post_rst_valid", 32'(idx_valid), 32'd1);
      chk("post_rst_idx", 32'(idx), 32'd0);
      drain(10, used);

      // Loads during SCAN and in the DONE cycle are ignored.
      do_load(8'b0000_0101);
      d    = 8'hF0;
      load = 1'b1;
      drain(20, used);
      load = 1'b0;
      d    = '0;
      chk("done_load_dropped", 32'(busy), 32'd0);
      cycle();
      chk("still_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
